// File: rtl/cache_pkg.sv
// Shared cache types and default widths.
// Used by the miss handler and the dual-port cache array.
package cache_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    FILL
  } miss_state_t;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
  } miss_entry_t;

endpackage

// File: rtl/miss_queue.sv
// Circular miss FIFO with duplicate-address filtering.
// Accepts up to two misses per cycle while two slots are free.
module miss_queue #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 4,
  localparam int PW        = $clog2(DEPTH),
  localparam int CW        = PW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_valid_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic                  b_valid_i,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic                  pop_i,
  output logic                  ready_o,
  output logic [ADDR_WIDTH-1:0] head_addr_o,
  output logic [CW-1:0]         count_o,
  output logic                  match_a_o,
  output logic                  match_b_o
);

  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [PW-1:0]         tail_b;
  logic [CW-1:0]         count_q, count_d;
  logic                  push_a, push_b;
  logic                  same_ab;

  always_comb begin
    match_a_o = 1'b0;
    match_b_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && addr_q[i] == a_addr_i)
        match_a_o = 1'b1;
      if (vld_q[i] && addr_q[i] == b_addr_i)
        match_b_o = 1'b1;
    end
  end

  assign ready_o = count_q <= CW'(DEPTH - 2);
  assign same_ab = a_valid_i && (a_addr_i == b_addr_i);

  assign push_a = a_valid_i && ready_o
               && !match_a_o;
  // B collapses onto A when both carry the same address
  assign push_b = b_valid_i && ready_o
               && !match_b_o && !same_ab;

  assign tail_b = tail_q + PW'(push_a);

  always_comb begin
    vld_d  = vld_q;
    addr_d = addr_q;
    if (pop_i)
      vld_d[head_q] = 1'b0;
    if (push_a) begin
      vld_d[tail_q]  = 1'b1;
      addr_d[tail_q] = a_addr_i;
    end
    if (push_b) begin
      vld_d[tail_b]  = 1'b1;
      addr_d[tail_b] = b_addr_i;
    end
    head_d  = head_q + PW'(pop_i);
    tail_d  = tail_q + PW'(push_a)
            + PW'(push_b);
    count_d = count_q + CW'(push_a)
            + CW'(push_b) - CW'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        addr_q[i] <= '0;
    end else begin
      vld_q   <= vld_d;
      addr_q  <= addr_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_addr_o = addr_q[head_q];
  assign count_o     = count_q;

endmodule

// File: rtl/cache_miss_handler.sv
// Miss-fill engine: queues read misses, fetches from memory,
// and writes each word into the cache through port A.
module cache_miss_handler #(
  parameter int DATA_WIDTH  = cache_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH  = cache_pkg::ADDR_WIDTH,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  miss_a_valid_i,
  input  logic [ADDR_WIDTH-1:0] miss_a_addr_i,
  input  logic                  miss_b_valid_i,
  input  logic [ADDR_WIDTH-1:0] miss_b_addr_i,
  output logic                  miss_ready_o,
  output logic                  mem_req_valid_o,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  input  logic                  mem_req_ready_i,
  input  logic                  mem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data_i,
  output logic                  cache_ce_o,
  output logic                  cache_we_o,
  output logic [ADDR_WIDTH-1:0] cache_addr_o,
  output logic [DATA_WIDTH-1:0] cache_wdata_o,
  output logic                  fill_busy_o,
  output logic                  fill_done_o
);

  import cache_pkg::*;

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  miss_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [CW-1:0]         count;
  logic                  pop;
  logic                  match_a, match_b;

  miss_queue #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (QUEUE_DEPTH)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .a_valid_i   (miss_a_valid_i),
    .a_addr_i    (miss_a_addr_i),
    .b_valid_i   (miss_b_valid_i),
    .b_addr_i    (miss_b_addr_i),
    .pop_i       (pop),
    .ready_o     (miss_ready_o),
    .head_addr_o (head_addr),
    .count_o     (count),
    .match_a_o   (match_a),
    .match_b_o   (match_b)
  );

  always_comb begin
    state_d         = state_q;
    data_d          = data_q;
    pop             = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_req_addr_o  = '0;
    cache_ce_o      = 1'b0;
    cache_we_o      = 1'b0;
    cache_addr_o    = '0;
    cache_wdata_o   = '0;
    fill_busy_o     = 1'b0;
    fill_done_o     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count != '0)
          state_d = REQ;
      end
      REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = head_addr;
        if (mem_req_ready_i)
          state_d = WAIT;
      end
      WAIT: begin
        if (mem_rsp_valid_i) begin
          data_d  = mem_rsp_data_i;
          state_d = FILL;
        end
      end
      FILL: begin
        // head stays queued until here so repeats get dropped
        cache_ce_o    = 1'b1;
        cache_we_o    = 1'b1;
        cache_addr_o  = head_addr;
        cache_wdata_o = data_q;
        fill_busy_o   = 1'b1;
        fill_done_o   = 1'b1;
        pop           = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_cache_miss_handler.sv
// Directed bench for cache_miss_handler.
// Acts as core-side miss source and as backing memory.
module tb_cache_miss_handler;

  logic        clk = 1'b0;
  logic        reset;
  logic        miss_a_valid_i;
  logic [7:0]  miss_a_addr_i;
  logic        miss_b_valid_i;
  logic [7:0]  miss_b_addr_i;
  logic        miss_ready_o;
  logic        mem_req_valid_o;
  logic [7:0]  mem_req_addr_o;
  logic        mem_req_ready_i;
  logic        mem_rsp_valid_i;
  logic [15:0] mem_rsp_data_i;
  logic        cache_ce_o;
  logic        cache_we_o;
  logic [7:0]  cache_addr_o;
  logic [15:0] cache_wdata_o;
  logic        fill_busy_o;
  logic        fill_done_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_miss_handler #(
    .DATA_WIDTH  (16),
    .ADDR_WIDTH  (8),
    .QUEUE_DEPTH (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .miss_a_valid_i  (miss_a_valid_i),
    .miss_a_addr_i   (miss_a_addr_i),
    .miss_b_valid_i  (miss_b_valid_i),
    .miss_b_addr_i   (miss_b_addr_i),
    .miss_ready_o    (miss_ready_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_data_i  (mem_rsp_data_i),
    .cache_ce_o      (cache_ce_o),
    .cache_we_o      (cache_we_o),
    .cache_addr_o    (cache_addr_o),
    .cache_wdata_o   (cache_wdata_o),
    .fill_busy_o     (fill_busy_o),
    .fill_done_o     (fill_done_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_outs(input string tag);
    chk({tag, "_reqv"}, 32'(mem_req_valid_o), 0);
    chk({tag, "_reqa"}, 32'(mem_req_addr_o), 0);
    chk({tag, "_ctl"},
        32'({cache_ce_o, cache_we_o,
             fill_busy_o, fill_done_o}), 0);
    chk({tag, "_caddr"}, 32'(cache_addr_o), 0);
    chk({tag, "_wdata"}, 32'(cache_wdata_o), 0);
    chk({tag, "_rdy"}, 32'(miss_ready_o), 1);
  endtask

  task automatic wait_req(input logic [7:0] a,
                          input string tag);
    int n = 0;
    while (!mem_req_valid_o && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_reqv"}, 32'(mem_req_valid_o), 1);
    chk({tag, "_reqa"}, 32'(mem_req_addr_o), 32'(a));
  endtask

  task automatic accept();
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
  endtask

  task automatic respond(input logic [15:0] d,
                         input logic [7:0] a,
                         input string tag);
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = d;
    tick();
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;
    chk({tag, "_fctl"},
        32'({cache_ce_o, cache_we_o,
             fill_busy_o, fill_done_o}), 32'hF);
    chk({tag, "_faddr"}, 32'(cache_addr_o), 32'(a));
    chk({tag, "_fdata"}, 32'(cache_wdata_o), 32'(d));
    tick();
    chk({tag, "_done0"}, 32'(fill_done_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [7:0] req_a;
    logic [7:0] ea;
    logic       pend;
    int         nxt;
    int         fills;

    reset           = 1'b1;
    miss_a_valid_i  = 1'b0;
    miss_a_addr_i   = '0;
    miss_b_valid_i  = 1'b0;
    miss_b_addr_i   = '0;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;
    tick();
    tick();
    reset = 1'b0;
    idle_outs("rst");

    // single miss, exact timing
    miss_a_valid_i = 1'b1;
    miss_a_addr_i  = 8'h35;
    tick();
    miss_a_valid_i = 1'b0;
    chk("t1_idle", 32'(mem_req_valid_o), 0);
    tick();
    chk("t1_reqv", 32'(mem_req_valid_o), 1);
    chk("t1_reqa", 32'(mem_req_addr_o), 32'h35);
    accept();
    chk("t1_wait", 32'(mem_req_valid_o), 0);
    respond(16'hBEEF, 8'h35, "t1");
    chk("t1_rdy", 32'(miss_ready_o), 1);
    tick();
    chk("t1_norep", 32'(mem_req_valid_o), 0);

    // distinct A and B in one cycle
    miss_a_valid_i = 1'b1;
    miss_a_addr_i  = 8'h10;
    miss_b_valid_i = 1'b1;
    miss_b_addr_i  = 8'h20;
    tick();
    miss_a_valid_i = 1'b0;
    miss_b_valid_i = 1'b0;
    wait_req(8'h10, "t2a");
    accept();
    respond(16'h1111, 8'h10, "t2a");
    wait_req(8'h20, "t2b");
    accept();
    respond(16'h2222, 8'h20, "t2b");
    tick();
    tick();
    chk("t2_norep", 32'(mem_req_valid_o), 0);

    // duplicates: A==B, then repeat while in flight
    miss_a_valid_i = 1'b1;
    miss_a_addr_i  = 8'h44;
    miss_b_valid_i = 1'b1;
    miss_b_addr_i  = 8'h44;
    tick();
    miss_b_valid_i = 1'b0;
    miss_a_valid_i = 1'b0;
    wait_req(8'h44, "t3");
    accept();
    miss_a_valid_i = 1'b1;
    tick();
    miss_a_valid_i = 1'b0;
    respond(16'h4444, 8'h44, "t3");
    for (int i = 0; i < 5; i++) begin
      chk("t3_norep", 32'(mem_req_valid_o), 0);
      tick();
    end
    chk("t3_rdy", 32'(miss_ready_o), 1);

    // back-pressure with memory stalled
    miss_a_valid_i = 1'b1;
    miss_a_addr_i  = 8'h01;
    miss_b_valid_i = 1'b1;
    miss_b_addr_i  = 8'h02;
    tick();
    chk("t4_rdy2", 32'(miss_ready_o), 1);
    miss_a_addr_i = 8'h03;
    miss_b_addr_i = 8'h04;
    tick();
    miss_b_valid_i = 1'b0;
    miss_a_addr_i  = 8'h05;
    chk("t4_full", 32'(miss_ready_o), 0);
    wait_req(8'h01, "t4s");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_stv", 32'(mem_req_valid_o), 1);
      chk("t4_sta", 32'(mem_req_addr_o), 32'h01);
      chk("t4_strdy", 32'(miss_ready_o), 0);
    end
    accept();
    respond(16'h0101, 8'h01, "t4a");
    chk("t4_rdy3", 32'(miss_ready_o), 0);
    wait_req(8'h02, "t4b");
    accept();
    respond(16'h0202, 8'h02, "t4b");
    chk("t4_rdyup", 32'(miss_ready_o), 1);
    tick();
    miss_a_valid_i = 1'b0;
    chk("t4_took", 32'(miss_ready_o), 0);
    wait_req(8'h03, "t4c");
    accept();
    respond(16'h0303, 8'h03, "t4c");
    wait_req(8'h04, "t4d");
    accept();
    respond(16'h0404, 8'h04, "t4d");
    wait_req(8'h05, "t4e");
    accept();
    respond(16'h0505, 8'h05, "t4e");

    // reset while waiting for memory
    miss_a_valid_i = 1'b1;
    miss_a_addr_i  = 8'h66;
    tick();
    miss_a_valid_i = 1'b0;
    wait_req(8'h66, "t5");
    accept();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_outs("t5r");
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 16'hDEAD;
    tick();
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;
    idle_outs("t5late");
    tick();
    tick();
    idle_outs("t5end");

    // ten misses, pointers wrap several times
    pend  = 1'b0;
    req_a = '0;
    nxt   = 0;
    fills = 0;
    mem_req_ready_i = 1'b1;
    for (int c = 0; c < 300 && fills < 10; c++) begin
      mem_rsp_valid_i = pend;
      mem_rsp_data_i  = {req_a, ~req_a};
      pend = 1'b0;
      if (nxt < 10) begin
        miss_a_valid_i = 1'b1;
        miss_a_addr_i  = 8'(8'h80 + nxt);
        if (miss_ready_o)
          nxt++;
      end else begin
        miss_a_valid_i = 1'b0;
      end
      if (mem_req_valid_o) begin
        pend  = 1'b1;
        req_a = mem_req_addr_o;
      end
      if (cache_we_o) begin
        ea = 8'(8'h80 + fills);
        chk("t6_addr", 32'(cache_addr_o), 32'(ea));
        chk("t6_data", 32'(cache_wdata_o),
            32'({ea, ~ea}));
        fills++;
      end
      tick();
    end
    miss_a_valid_i  = 1'b0;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    chk("t6_fills", 32'(fills), 10);
    chk("t6_acc", 32'(nxt), 10);
    tick();
    tick();
    idle_outs("t6end");

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
